mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 4, memory-access cycles per transaction (legal 1..15).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0 / req1  input  1  request from port 0 (fetch) / port 1 (data).
REQ-005 wr0 / wr1  input  1  1 = write, 0 = read, for that port.
REQ-006 addr0 / addr1  input  16  byte address; bit 0 ignored.
REQ-007 wdata0 / wdata1  input  16  write data.
REQ-008 ack0 / ack1  output  1  combinational accept pulse; request is captured at the same edge.
REQ-009 done0 / done1  output  1  one-cycle completion pulse for the owning port.
REQ-010 rdata  output  16  read data, valid while done0 or done1 is high for a read.
REQ-011 busy  output  1  high while a transaction is in flight.
REQ-012 mem_enable, mem_wr  output  1  memory enable and write strobe.
REQ-013 mem_addr  output  16  memory address, bit 0 forced to 0.
REQ-014 mem_data_in  output  16  memory write data.
REQ-015 mem_data_out  input  16  combinational memory read data.

Function
REQ-016 States IDLE and BUSY; a 4-bit down-counter tracks the remaining access cycles.
REQ-017 IDLE with req0 or req1 high: assert ack for the winner only, latch its wr/addr/wdata/port id, load counter with LATENCY, go to BUSY.
REQ-018 IDLE with no request: stay IDLE, ack0 = ack1 = 0.
REQ-019 Simultaneous requests: grant the port that did not win the last grant (round-robin); the last-grant register resets to port 1, so port 0 wins first.
REQ-020 BUSY: decrement the counter each cycle; ack0 = ack1 = 0; requests are held by the requester and ignored.
REQ-021 mem_enable and mem_wr (for writes) are asserted only in the BUSY cycle with counter == 1; 0 in every other cycle.
REQ-022 mem_addr and mem_data_in present the latched values throughout BUSY and are 0 in IDLE.
REQ-023 At the edge ending the counter == 1 cycle: capture mem_data_out into rdata for a read (the write commits in memory at that edge) and return to IDLE.
REQ-024 In the first IDLE cycle after BUSY, pulse done for the owning port for exactly one cycle.
REQ-025 rdata holds its value until the next read completes; a write leaves rdata unchanged.
REQ-026 A new request may be acked in the same cycle as done, giving one transaction every LATENCY+1 cycles.
REQ-027 busy = 1 exactly when the state is BUSY.
REQ-028 With LATENCY = 1, the memory is enabled in the single BUSY cycle immediately after ack.

Reset
REQ-029 On rst: state IDLE, counter 0, last-grant = port 1, rdata = 0; all outputs 0.
REQ-030 rst during BUSY aborts the transaction: no mem_enable in the reset cycle, no done is produced, and a pending write is dropped.
REQ-031 rst has priority over every request in the same cycle; no ack is given.

Configuration
REQ-032 Macro MEM_ARBITER_FIXED_PRIO_EN defined: port 1 (data) always wins simultaneous requests and the last-grant register is unused.
REQ-033 Macro MEM_ARBITER_FIXED_PRIO_EN undefined: round-robin per REQ-019.

Verification
REQ-034 LATENCY=4, rst released, req1 write addr 0x0010 data 0xBEEF at cycle 0 -> ack1 at cycle 0, mem_enable & mem_wr only at cycle 4, done1 at cycle 5; a later port-0 read of 0x0010 returns rdata 0xBEEF with done0.
REQ-035 req0 and req1 both high from reset, both held until acked -> grants alternate 0,1,0,1 (round-robin build); with MEM_ARBITER_FIXED_PRIO_EN, port 1 wins every contested cycle.
REQ-036 Read of addr 0x0021 after a write of 0x1234 to 0x0020 -> mem_addr 0x0020, rdata 0x1234.
REQ-037 rst asserted at cycle 2 of a write of 0xAAAA to 0x0040 -> no mem_enable, no done; a following read of 0x0040 returns the prior contents.
REQ-038 Back-to-back: req0 held after done0 -> the next ack0 is in the same cycle as done0; period is 5 cycles at LATENCY=4 and 2 cycles at LATENCY=1.
REQ-039 Requests toggled during BUSY -> ack0 = ack1 = 0 and latched addr/wdata are unchanged until done.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch/data) arbiter in front of a single-ported memory.
// A transaction is granted in IDLE, holds the memory for LATENCY cycles in BUSY,
// and the memory access itself happens in the last BUSY cycle (counter == 1).
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req0/1, wr0/1               request and write/read select (0 = fetch, 1 = data)
//   addr0/1, wdata0/1           byte address (bit 0 ignored) and write data
//   ack0/1                      combinational accept, request captured at same edge
//   done0/1                     one-cycle completion pulse for the owning port
//   rdata                       read data, valid with done for a read, held otherwise
//   busy                        transaction in flight
//   mem_enable, mem_wr          memory enable / write strobe (last BUSY cycle only)
//   mem_addr, mem_data_in       latched address (bit 0 = 0) and write data, 0 in IDLE
//   mem_data_out                combinational memory read data
//
// Configuration macro: MEM_ARBITER_FIXED_PRIO_EN
//   defined   -> port 1 always wins simultaneous requests
//   undefined -> round-robin, port 0 wins the first contested cycle after reset

module mem_arbiter #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               lat_wr;
  logic               lat_port;
  logic [15:0]        lat_addr;
  logic [15:0]        lat_wdata;
  logic               grant1;
  logic               accept;

`ifndef MEM_ARBITER_FIXED_PRIO_EN
  logic               last_grant;
`endif

  // Winner selection; only meaningful when at least one request is high
  always_comb begin
    grant1 = 1'b0;
    if (req0 && req1) begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
      grant1 = 1'b1;
`else
      grant1 = ~last_grant;
`endif
    end else begin
      grant1 = req1;
    end
  end

  // Accept only in IDLE; reset suppresses any grant in the same cycle
  assign accept = (state == IDLE) && !rst && (req0 || req1);
  assign ack0   = accept && !grant1;
  assign ack1   = accept && grant1;

  // Memory strobes decode the final BUSY cycle; gating with rst drops an
  // access whose commit edge coincides with reset
  assign mem_enable  = (state == BUSY) && (cnt == CNT_W'(1)) && !rst;
  assign mem_wr      = mem_enable && lat_wr;
  assign mem_addr    = lat_addr;
  assign mem_data_in = lat_wdata;
  assign busy        = (state == BUSY);

  // Arbiter state, latched request and completion outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_wr     <= 1'b0;
      lat_port   <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rdata      <= '0;
      done0      <= 1'b0;
      done1      <= 1'b0;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= BUSY;
            cnt       <= CNT_W'(LATENCY);
            lat_port  <= grant1;
            lat_wr    <= grant1 ? wr1 : wr0;
            lat_addr  <= (grant1 ? addr1 : addr0) & 16'hFFFE;
            lat_wdata <= grant1 ? wdata1 : wdata0;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
            last_grant <= grant1;
`endif
          end
        end
        BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            if (!lat_wr) rdata <= mem_data_out;
            done0     <= ~lat_port;
            done1     <= lat_port;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: acks push expected transactions, dones pop
// and check owner, latency and read data against a bench-side reference memory.
module tb_mem_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 0, req1 = 0, wr0 = 0, wr1 = 0;
  logic [15:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic        ack0, ack1, done0, done1, busy, mem_enable, mem_wr;
  logic [15:0] rdata, mem_addr, mem_data_in, mem_data_out;

  // second instance at LATENCY = 1
  logic        b_req0 = 0;
  logic        b_ack0, b_ack1, b_done0, b_done1, b_busy, b_men, b_mwr;
  logic [15:0] b_rdata, b_maddr, b_mdin;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [15:0] mem     [0:32767];
  logic [15:0] ref_mem [0:32767];

  typedef struct {
    logic        port;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          acyc;
  } txn_t;
  txn_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1), .rdata(rdata),
    .busy(busy), .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  mem_arbiter #(.LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .req0(b_req0), .req1(1'b0), .wr0(1'b0), .wr1(1'b0),
    .addr0(16'h0010), .addr1(16'h0000), .wdata0(16'h0000), .wdata1(16'h0000),
    .ack0(b_ack0), .ack1(b_ack1), .done0(b_done0), .done1(b_done1), .rdata(b_rdata),
    .busy(b_busy), .mem_enable(b_men), .mem_wr(b_mwr), .mem_addr(b_maddr),
    .mem_data_in(b_mdin), .mem_data_out(16'h0000)
  );

  // Memory model behind the main DUT
  assign mem_data_out = mem[mem_addr[15:1]];
  always @(posedge clk) if (mem_enable && mem_wr) mem[mem_addr[15:1]] <= mem_data_in;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (mem_enable) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL sb_men_idle: mem_enable=1 required 0 (no txn)");
        end else if (mem_addr !== (sb[0].addr & 16'hFFFE) || mem_wr !== sb[0].wr) begin
          n_err++;
          $display("FAIL sb_mem_port: addr=%h wr=%b required addr=%h wr=%b",
                   mem_addr, mem_wr, sb[0].addr & 16'hFFFE, sb[0].wr);
        end
      end
      if (done0 || done1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL sb_done_empty: done0=%b done1=%b required none", done0, done1);
        end else begin
          txn_t e;
          e = sb.pop_front();
          if (done1 !== e.port || done0 !== !e.port || (cyc - e.acyc) != LAT + 1) begin
            n_err++;
            $display("FAIL sb_done: done0=%b done1=%b lat=%0d required port=%b lat=%0d",
                     done0, done1, cyc - e.acyc, e.port, LAT + 1);
          end else if (e.wr) begin
            ref_mem[e.addr[15:1]] = e.wdata;
          end else if (rdata !== ref_mem[e.addr[15:1]]) begin
            n_err++;
            $display("FAIL sb_rdata: rdata=%h required %h", rdata, ref_mem[e.addr[15:1]]);
          end
        end
      end
      if (ack0 || ack1) begin
        txn_t t;
        t.port  = ack1;
        t.wr    = ack1 ? wr1 : wr0;
        t.addr  = ack1 ? addr1 : addr0;
        t.wdata = ack1 ? wdata1 : wdata0;
        t.acyc  = cyc;
        sb.push_back(t);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Issue one request, hold until ack, then wait for done (bounded)
  task automatic run_txn(input logic port, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wdata);
    bit got;
    tick();
    if (port) begin req1 = 1; wr1 = wr; addr1 = addr; wdata1 = wdata; end
    else      begin req0 = 1; wr0 = wr; addr0 = addr; wdata0 = wdata; end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (port ? ack1 : ack0) got = 1;
      else tick();
    end
    tick();
    req0 = 0; req1 = 0;
    if (!got) begin
      n_cmp++; n_err++; $display("FAIL ack_timeout: port=%b no ack required ack", port);
      return;
    end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (port ? done1 : done0) got = 1;
    end
    if (!got) begin
      n_cmp++; n_err++; $display("FAIL done_timeout: port=%b no done required done", port);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1; req1 = 1;
    tick(); tick();
    @(negedge clk);
    n_cmp++;
    if ({ack0, ack1, done0, done1, busy, mem_enable, mem_wr} !== 7'b0 ||
        rdata !== 16'h0 || mem_addr !== 16'h0 || mem_data_in !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outputs: ctl=%b rdata=%h maddr=%h required all 0",
               {ack0, ack1, done0, done1, busy, mem_enable, mem_wr}, rdata, mem_addr);
    end
    tick();
    rst = 1'b0; req0 = 0; req1 = 0;
  endtask

  task automatic test_write_read();
    logic [3:0] obs, exp;
    req1 = 1; wr1 = 1; addr1 = 16'h0010; wdata1 = 16'hBEEF;
    @(negedge clk);
    n_cmp++;
    if (ack1 !== 1'b1 || ack0 !== 1'b0) begin
      n_err++; $display("FAIL wr_ack: ack0=%b ack1=%b required 0 1", ack0, ack1);
    end
    tick();
    req1 = 0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      obs = {mem_enable, mem_wr, done1, busy};
      exp = {k == LAT, k == LAT, k == LAT + 1, k <= LAT};
      n_cmp++;
      if (obs !== exp) begin
        n_err++; $display("FAIL wr_cycle%0d: men/mwr/done1/busy=%b required %b", k, obs, exp);
      end
      if (k <= LAT) tick();
    end
    run_txn(0, 0, 16'h0010, 16'h0);
    n_cmp++;
    if (rdata !== 16'hBEEF) begin
      n_err++; $display("FAIL rd_beef: rdata=%h required beef", rdata);
    end
  endtask

  task automatic test_round_robin();
    logic g [0:3];
    logic exp;
    int ng = 0;
    do_reset();
    req0 = 1; req1 = 1; wr0 = 0; wr1 = 0; addr0 = 16'h0100; addr1 = 16'h0102;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      @(negedge clk);
      if (ack0 && ack1) begin
        n_cmp++; n_err++; $display("FAIL rr_dual: ack0=1 ack1=1 required one");
      end
      if (ack0 || ack1) begin g[ng] = ack1; ng++; end
      tick();
    end
    req0 = 0; req1 = 0;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
      exp = 1'b1;
`else
      exp = k[0];
`endif
      n_cmp++;
      if (k >= ng || g[k] !== exp) begin
        n_err++; $display("FAIL rr_grant%0d: got=%b (n=%0d) required %b", k, g[k], ng, exp);
      end
    end
    for (int i = 0; i < 10 && busy; i++) tick();
    @(negedge clk);
  endtask

  task automatic test_addr_bit0();
    run_txn(0, 1, 16'h0020, 16'h1234);
    run_txn(1, 0, 16'h0021, 16'h0);
    n_cmp++;
    if (rdata !== 16'h1234) begin
      n_err++; $display("FAIL odd_addr_rd: rdata=%h required 1234", rdata);
    end
  endtask

  task automatic test_reset_abort();
    logic [15:0] prior;
    logic [3:0]  obs;
    prior = ref_mem[16'h0040 >> 1];
    tick();
    req0 = 1; wr0 = 1; addr0 = 16'h0040; wdata0 = 16'hAAAA;
    @(negedge clk);
    n_cmp++;
    if (ack0 !== 1'b1) begin
      n_err++; $display("FAIL abort_ack: ack0=%b required 1", ack0);
    end
    tick(); req0 = 0;
    tick(); rst = 1;
    @(negedge clk);
    n_cmp++;
    if (mem_enable !== 1'b0 || ack0 !== 1'b0) begin
      n_err++; $display("FAIL abort_rstcyc: men=%b ack0=%b required 0 0", mem_enable, ack0);
    end
    tick(); rst = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      obs = {mem_enable, done0, done1, busy};
      n_cmp++;
      if (obs !== 4'b0) begin
        n_err++; $display("FAIL abort_quiet%0d: men/d0/d1/busy=%b required 0000", i, obs);
      end
      tick();
    end
    run_txn(0, 0, 16'h0040, 16'h0);
    n_cmp++;
    if (rdata !== prior) begin
      n_err++; $display("FAIL abort_rd: rdata=%h required %h", rdata, prior);
    end
  endtask

  task automatic test_back_to_back();
    int t [0:2];
    int na = 0;
    tick();
    req0 = 1; wr0 = 0; addr0 = 16'h0010;
    for (int i = 0; i < 30 && na < 3; i++) begin
      @(negedge clk);
      if (ack0) begin
        if (na > 0) begin
          n_cmp++;
          if (done0 !== 1'b1 || i - t[na-1] != LAT + 1) begin
            n_err++;
            $display("FAIL b2b_ack%0d: done0=%b period=%0d required 1 %0d",
                     na, done0, i - t[na-1], LAT + 1);
          end
        end
        t[na] = i; na++;
      end else if (done0) begin
        n_cmp++; n_err++; $display("FAIL b2b_noack: ack0=0 with done0 required 1");
      end
      tick();
    end
    req0 = 0;
    n_cmp++;
    if (na != 3) begin
      n_err++; $display("FAIL b2b_count: acks=%0d required 3", na);
    end
    for (int i = 0; i < 10 && busy; i++) tick();
    @(negedge clk);
  endtask

  task automatic test_hold();
    tick();
    req1 = 1; wr1 = 1; addr1 = 16'h0080; wdata1 = 16'h1111;
    @(negedge clk);
    tick();
    for (int k = 1; k <= LAT; k++) begin
      req0 = 1'($urandom); req1 = 1'($urandom); wr1 = 1'($urandom);
      addr1 = 16'($urandom); wdata1 = 16'($urandom);
      @(negedge clk);
      n_cmp++;
      if (ack0 || ack1 || mem_addr !== 16'h0080 || mem_data_in !== 16'h1111 || !busy) begin
        n_err++;
        $display("FAIL hold%0d: ack=%b%b maddr=%h mdin=%h busy=%b required 00 0080 1111 1",
                 k, ack0, ack1, mem_addr, mem_data_in, busy);
      end
      tick();
    end
    req0 = 0; req1 = 0;
    @(negedge clk);
    n_cmp++;
    if (done1 !== 1'b1) begin
      n_err++; $display("FAIL hold_done: done1=%b required 1", done1);
    end
    run_txn(0, 0, 16'h0080, 16'h0);
    n_cmp++;
    if (rdata !== 16'h1111) begin
      n_err++; $display("FAIL hold_rd: rdata=%h required 1111", rdata);
    end
  endtask

  task automatic test_latency1();
    logic [2:0] obs, exp;
    tick();
    b_req0 = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      obs = {b_ack0, b_men, b_done0};
      exp = {i % 2 == 0, i % 2 == 1, i > 0 && i % 2 == 0};
      n_cmp++;
      if (obs !== exp) begin
        n_err++; $display("FAIL lat1_c%0d: ack/men/done=%b required %b", i, obs, exp);
      end
      tick();
    end
    b_req0 = 0;
    tick(); tick();
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i]     = 16'(i * 16'h0101) ^ 16'h5A5A;
      ref_mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
    end
    test_reset();
    test_write_read();
    test_round_robin();
    test_addr_bit0();
    test_reset_abort();
    test_back_to_back();
    test_hold();
    test_latency1();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL sb_leftover: pending=%0d required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
